// File: rtl/led_pov_pkg.sv
// Shared types and defaults for the POV LED column driver.
// Holds the column FSM state enumeration and the geometry/timing defaults.
package led_pov_pkg;

    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned CLK_DIV_DEF = 2;
    localparam int unsigned CLK_DIV_MAX = 15;
    localparam int unsigned NUM_COLS    = 80;

    // Phase counter only ever holds CLK_DIV-1, so size it for the largest legal divider.
    localparam int unsigned PHASE_W = $clog2(CLK_DIV_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } col_state_e;

endpackage

// File: rtl/pov_phase_timer.sv
// Half-period timer: reloads on load, counts down to zero and holds there.
// expired is high while the count is zero, i.e. in the last cycle of a phase.
module pov_phase_timer
    import led_pov_pkg::*;
#(
    parameter int unsigned W = PHASE_W
) (
    input  logic         clk_out,
    input  logic         reset_new,
    input  logic         load,
    input  logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    // Saturating down-counter so a phase can never wrap mid-bit.
    always_ff @(posedge clk_out or posedge reset_new) begin
        if (reset_new) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= count;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/led_col_shifter.sv
// Shifts one display column into a serial LED driver chain, MSB first,
// then latches it; handshakes column words from the display RAM reader.
module led_col_shifter
    import led_pov_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic              clk_out,
    input  logic              reset_new,
    input  logic              col_valid,
    input  logic [DATA_W-1:0] col_data,
    output logic              col_ready,
    input  logic              blank,
    output logic              led_sdi,
    output logic              led_sclk,
    output logic              led_latch,
    output logic              led_oe_n,
    output logic              col_done,
    output logic              overrun
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    if (CLK_DIV < 1 || CLK_DIV > CLK_DIV_MAX) begin : g_bad_div
        $error("led_col_shifter: CLK_DIV out of range 1..15");
    end

    col_state_e        state_q;
    col_state_e        state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BIT_W-1:0]  bit_q;
    logic [BIT_W-1:0]  bit_d;
    logic              accept;
    logic              phase_load;
    logic              phase_expired;
    logic              seen_done_q;

    // col_ready is only ever high in IDLE, so it alone qualifies the handshake.
    assign accept     = col_valid && col_ready;
    assign phase_load = (state_d != state_q);

    pov_phase_timer #(
        .W(PHASE_W)
    ) u_phase_timer (
        .clk_out  (clk_out),
        .reset_new(reset_new),
        .load     (phase_load),
        .count    (PHASE_W'(CLK_DIV - 1)),
        .expired  (phase_expired)
    );

    // State register together with the datapath it sequences.
    always_ff @(posedge clk_out or posedge reset_new) begin
        if (reset_new) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT_LO;
                    shift_d = col_data;
                    bit_d   = BIT_W'(DATA_W - 1);
                end
            end
            SHIFT_LO: begin
                if (phase_expired) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_expired) begin
                    if (bit_q != '0) begin
                        state_d = SHIFT_LO;
                        shift_d = shift_q << 1;
                        bit_d   = bit_q - BIT_W'(1);
                    end else begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                if (phase_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge clk_out or posedge reset_new) begin
        if (reset_new) begin
            col_ready   <= 1'b0;
            led_sdi     <= 1'b0;
            led_sclk    <= 1'b0;
            led_latch   <= 1'b0;
            led_oe_n    <= 1'b1;
            col_done    <= 1'b0;
            overrun     <= 1'b0;
            seen_done_q <= 1'b0;
        end else begin
            col_ready <= (state_d == IDLE);
            led_sclk  <= (state_d == SHIFT_HI);
            led_latch <= (state_d == LATCH);
            col_done  <= (state_d == DONE);
            if (state_d == SHIFT_LO && state_q != SHIFT_LO) begin
                led_sdi <= shift_d[DATA_W-1];
            end
            if (col_valid && !col_ready) begin
                overrun <= 1'b1;
            end
            seen_done_q <= seen_done_q | (state_d == DONE);
            // Keep the LEDs dark until a complete column has been latched.
            led_oe_n    <= seen_done_q ? blank : 1'b1;
        end
    end

endmodule

// File: tb/tb_led_col_shifter.sv
// Randomized bench for led_col_shifter: two instances (CLK_DIV=2 and 1) are
// compared every cycle against a column-timeline model computed from offsets.
module tb_led_col_shifter;
    import led_pov_pkg::*;

    localparam int W     = 16;
    localparam int NCYC  = 6000;

    logic          clk_out = 1'b0;
    logic          reset_new;
    logic          blank;
    logic [1:0]    col_valid;
    logic [W-1:0]  col_data [2];
    logic [1:0]    col_ready, led_sdi, led_sclk, led_latch, led_oe_n, col_done, overrun;

    int checks   = 0;
    int failures = 0;

    // Reference state: position of the current column in its timeline.
    int           cd      [2];
    bit           m_busy  [2];
    int           m_d     [2];
    logic [W-1:0] m_data  [2];
    bit           m_ready [2];
    bit           m_ovr   [2];
    bit           m_seen  [2];
    bit           m_oe    [2];
    bit           m_sdi   [2];
    bit           first   [2];
    int           rst_hold;

    always #5 clk_out = ~clk_out;

    led_col_shifter #(.DATA_W(W), .CLK_DIV(2)) u_dut0 (
        .clk_out  (clk_out),
        .reset_new(reset_new),
        .col_valid(col_valid[0]),
        .col_data (col_data[0]),
        .col_ready(col_ready[0]),
        .blank    (blank),
        .led_sdi  (led_sdi[0]),
        .led_sclk (led_sclk[0]),
        .led_latch(led_latch[0]),
        .led_oe_n (led_oe_n[0]),
        .col_done (col_done[0]),
        .overrun  (overrun[0])
    );

    led_col_shifter #(.DATA_W(W), .CLK_DIV(1)) u_dut1 (
        .clk_out  (clk_out),
        .reset_new(reset_new),
        .col_valid(col_valid[1]),
        .col_data (col_data[1]),
        .col_ready(col_ready[1]),
        .blank    (blank),
        .led_sdi  (led_sdi[1]),
        .led_sclk (led_sclk[1]),
        .led_latch(led_latch[1]),
        .led_oe_n (led_oe_n[1]),
        .col_done (col_done[1]),
        .overrun  (overrun[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset(input int j);
        m_busy[j]  = 1'b0;
        m_d[j]     = 0;
        m_ready[j] = 1'b0;
        m_ovr[j]   = 1'b0;
        m_seen[j]  = 1'b0;
        m_oe[j]    = 1'b1;
        m_sdi[j]   = 1'b0;
    endtask

    // Compare one instance against the expected waveform for its column offset.
    task automatic check_dut(input int j);
        int  c;
        int  shift_end;
        int  done_d;
        bit  e_sclk;
        bit  e_latch;
        bit  e_done;
        c         = cd[j];
        shift_end = 2 * c * W;
        done_d    = shift_end + c + 1;
        e_sclk    = m_busy[j] && m_d[j] <= shift_end && ((m_d[j] - 1) % (2 * c)) >= c;
        e_latch   = m_busy[j] && m_d[j] > shift_end && m_d[j] <= shift_end + c;
        e_done    = m_busy[j] && m_d[j] == done_d;
        check($sformatf("d%0d.ready", j),   32'(col_ready[j]), 32'(m_ready[j]));
        check($sformatf("d%0d.sclk", j),    32'(led_sclk[j]),  32'(e_sclk));
        check($sformatf("d%0d.latch", j),   32'(led_latch[j]), 32'(e_latch));
        check($sformatf("d%0d.done", j),    32'(col_done[j]),  32'(e_done));
        check($sformatf("d%0d.sdi", j),     32'(led_sdi[j]),   32'(m_sdi[j]));
        check($sformatf("d%0d.overrun", j), 32'(overrun[j]),   32'(m_ovr[j]));
        check($sformatf("d%0d.oe_n", j),    32'(led_oe_n[j]),  32'(m_oe[j]));
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step(input int j);
        int c;
        int done_d;
        int idx;
        c      = cd[j];
        done_d = 2 * c * W + c + 1;
        if (reset_new) begin
            model_reset(j);
            return;
        end
        m_oe[j] = m_seen[j] ? blank : 1'b1;
        if (m_busy[j] && (m_d[j] + 1) == done_d) begin
            m_seen[j] = 1'b1;
        end
        if (col_valid[j] && !m_ready[j]) begin
            m_ovr[j] = 1'b1;
        end
        if (m_busy[j]) begin
            m_d[j]++;
            if (m_d[j] > done_d) begin
                m_busy[j] = 1'b0;
            end
        end else if (m_ready[j] && col_valid[j]) begin
            m_busy[j] = 1'b1;
            m_d[j]    = 1;
            m_data[j] = col_data[j];
        end
        m_ready[j] = !m_busy[j];
        if (m_busy[j] && m_d[j] <= 2 * c * W) begin
            idx      = W - 1 - (m_d[j] - 1) / (2 * c);
            m_sdi[j] = m_data[j][idx];
        end
    endtask

    task automatic drive_inputs(input int cyc);
        if (cyc < 3) begin
            reset_new = 1'b1;
        end else if (rst_hold > 0) begin
            rst_hold--;
            reset_new = (rst_hold > 0);
        end else if ($urandom_range(0, 399) == 0) begin
            rst_hold  = $urandom_range(1, 3);
            reset_new = 1'b1;
        end else begin
            reset_new = 1'b0;
        end
        if ($urandom_range(0, 29) == 0) begin
            blank = ~blank;
        end
        for (int j = 0; j < 2; j++) begin
            if (m_ready[j]) begin
                col_valid[j] = 1'($urandom_range(0, 1));
            end else begin
                col_valid[j] = ($urandom_range(0, 15) == 0);
            end
            col_data[j] = W'($urandom);
            if (first[j]) begin
                col_data[j] = (j == 0) ? 16'hA5C3 : 16'h5555;
                if (col_valid[j] && m_ready[j] && !reset_new) begin
                    first[j] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        cd[0]       = 2;
        cd[1]       = 1;
        reset_new   = 1'b1;
        blank       = 1'b0;
        col_valid   = '0;
        col_data[0] = '0;
        col_data[1] = '0;
        rst_hold    = 0;
        for (int j = 0; j < 2; j++) begin
            model_reset(j);
            m_data[j] = '0;
            first[j]  = 1'b1;
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk_out);
            for (int j = 0; j < 2; j++) begin
                check_dut(j);
            end
            drive_inputs(cyc);
            for (int j = 0; j < 2; j++) begin
                model_step(j);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_col_shifter.md
LED_COL_SHIFTER -- requirements
Module: led_col_shifter

Interface
REQ-001 Parameter DATA_W, default 16, LEDs per column (bits shifted per column).
REQ-002 Parameter CLK_DIV, default 2, clk_out cycles per led_sclk half-period; legal range 1..15.
REQ-003 clk_out  in  1  system clock; every register is clocked on its rising edge.
REQ-004 reset_new  in  1  asynchronous, active-high reset.
REQ-005 col_valid  in  1  column word on col_data is valid this cycle.
REQ-006 col_data  in  DATA_W  column pixel word, read from display RAM at the current column address.
REQ-007 col_ready  out  1  block can accept a column word.
REQ-008 blank  in  1  forces the LEDs dark.
REQ-009 led_sdi  out  1  serial data to the LED driver chain, MSB first.
REQ-010 led_sclk  out  1  LED driver shift clock.
REQ-011 led_latch  out  1  LED driver storage-register latch strobe.
REQ-012 led_oe_n  out  1  LED driver output enable, active-low.
REQ-013 col_done  out  1  one-cycle pulse when a column has been latched.
REQ-014 overrun  out  1  sticky flag: a column word was offered while not ready.

Function
REQ-015 The state machine SHALL use these states: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
REQ-016 col_ready SHALL be 1 only in IDLE; the handshake is complete on any rising edge where col_valid=1 and col_ready=1.
REQ-017 On acceptance the block SHALL capture col_data into the shift register, load the bit counter with DATA_W-1, and enter SHIFT_LO on the next cycle.
REQ-018 SHIFT_LO SHALL hold led_sclk=0 for CLK_DIV cycles, with led_sdi = current MSB; led_sdi changes only on entry to SHIFT_LO.
REQ-019 SHIFT_HI SHALL hold led_sclk=1 for CLK_DIV cycles.
REQ-020 On leaving SHIFT_HI, if the bit counter is greater than 0, the block SHALL shift left, decrement the counter and return to SHIFT_LO; otherwise it SHALL enter LATCH.
REQ-021 LATCH SHALL hold led_latch=1 and led_sclk=0 for CLK_DIV cycles, then enter DONE.
REQ-022 DONE SHALL last 1 cycle with col_done=1, then return to IDLE.
REQ-023 Latency: with acceptance on edge t0, col_done SHALL be high in cycle t0+1+2*CLK_DIV*DATA_W+CLK_DIV; for the defaults this is t0+67, and col_ready returns to 1 at t0+68.
REQ-024 Exactly DATA_W rising edges of led_sclk and exactly one led_latch pulse SHALL occur per accepted column.
REQ-025 If col_valid=1 while col_ready=0, the word SHALL be dropped, overrun SHALL be set to 1, and overrun SHALL clear only on reset.
REQ-026 led_oe_n SHALL remain 1 until the first col_done; afterwards it SHALL equal blank, registered with 1-cycle latency.
REQ-027 blank SHALL NOT affect shifting, latching or the handshake.
REQ-028 The phase counter and the bit counter SHALL each be wide enough for their ranges and SHALL NOT wrap mid-bit; the phase counter reloads on every state change.
REQ-029 A col_valid that coincides with DONE SHALL count as an overrun; back-to-back columns require col_valid in IDLE.

Reset
REQ-030 While reset_new=1, outputs SHALL be: col_ready=0, led_sdi=0, led_sclk=0, led_latch=0, led_oe_n=1, col_done=0, overrun=0; state SHALL be IDLE.
REQ-031 col_ready SHALL go to 1 on the first clk_out edge after reset_new is released.
REQ-032 Reset asserted mid-column SHALL abandon the shift with no led_latch pulse and no col_done.

Structure
REQ-033 Package led_pov_pkg SHALL hold the state enumeration and the DATA_W and CLK_DIV defaults; the column count (80) also belongs there for shared use.
REQ-034 The half-period counter SHALL be a sub-module, pov_phase_timer, with inputs load and count value and an output expired.

Verification
REQ-035 Defaults; col_data=16'hA5C3 offered at t0 -> at the 16 rising edges of led_sclk, led_sdi = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; led_latch high in cycles t0+65 and t0+66; col_done in cycle t0+67.
REQ-036 Columns 16'hFFFF then 16'h0001, each offered on the first cycle col_ready is high -> exactly 32 rising edges of led_sclk, 2 latch pulses, overrun=0.
REQ-037 col_valid pulsed at t0+10 during a shift -> overrun=1 and stays 1, current column completes unchanged, no extra led_sclk edges.
REQ-038 reset_new asserted at t0+30 -> led_sclk=0, led_latch stays 0, col_done is never asserted, led_oe_n=1; after release a new 16'h8001 column shifts correctly.
REQ-039 blank=1 after the first col_done -> led_oe_n=1 one cycle later; blank=0 -> led_oe_n=0; shifting is unaffected.
REQ-040 CLK_DIV=1 with 16'h5555 -> led_sclk toggles every cycle and col_done occurs at t0+34.
